// File: rtl/imem_dmem_port_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch and load/store.
// Data wins ties unless a fetch has already waited through STARVE_LIMIT data grants.
module imem_dmem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_valid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_stall_o,
  input  logic                flush_i,
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [DATA_W/8-1:0] dm_wstrb_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  output logic                dm_valid_o,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                dm_stall_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_ready_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                drop_q, drop_d;
  logic [STREAK_W-1:0] d_streak_q, d_streak_d;
  logic                fetch_starved_s;

  // A waiting fetch that has sat through STARVE_LIMIT data grants takes the next slot.
  assign fetch_starved_s = if_req_i & (d_streak_q == STREAK_MAX);

  // State, memory-side request registers, drop flag and data-grant streak.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wstrb_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      drop_q      <= 1'b0;
      d_streak_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      drop_q      <= drop_d;
      d_streak_q  <= d_streak_d;
    end
  end

  // Arbitration in IDLE, completion and flush tracking in the busy states.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    drop_d      = drop_q;
    d_streak_d  = d_streak_q;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (dm_req_i && !fetch_starved_s) begin
          state_d     = D_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_wstrb_d = dm_wstrb_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          if (!if_req_i) begin
            d_streak_d = '0;
          end else if (d_streak_q != STREAK_MAX) begin
            d_streak_d = d_streak_q + STREAK_ONE;
          end else begin
            d_streak_d = d_streak_q;
          end
        end else if (if_req_i) begin
          state_d     = I_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_wstrb_d = '0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          d_streak_d  = '0;
        end else begin
          d_streak_d = '0;
        end
      end
      I_BUSY: begin
        if (mem_ready_i) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
        end else if (flush_i) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      D_BUSY: begin
        if (mem_ready_i) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        drop_d    = 1'b0;
      end
    endcase
  end

  // Responses are combinational in the mem_ready cycle; a flush in that cycle also kills the fetch.
  assign if_valid_o  = (state_q == I_BUSY) & mem_ready_i & ~drop_q & ~flush_i;
  assign dm_valid_o  = (state_q == D_BUSY) & mem_ready_i;
  assign if_rdata_o  = mem_rdata_i;
  assign dm_rdata_o  = mem_rdata_i;
  assign if_stall_o  = if_req_i & ~if_valid_o;
  assign dm_stall_o  = dm_req_i & ~dm_valid_o;

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_wstrb_o = mem_wstrb_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
